// File: rtl/expr_pkg.sv
// Shared definitions for the expression checker: FSM encoding, the ASCII
// characters the grammar recognises, and the character-class bundle.
package expr_pkg;

    // Parser state: waiting for an operand, operand just finished, or failed.
    typedef enum logic [1:0] {
        EXPECT = 2'b00,
        DONE   = 2'b01,
        ERR    = 2'b11
    } state_e;

    localparam logic [7:0] CH_DIGIT_LO = 8'd48;  // '0'
    localparam logic [7:0] CH_DIGIT_HI = 8'd57;  // '9'
    localparam logic [7:0] CH_PLUS     = 8'd43;  // '+'
    localparam logic [7:0] CH_MINUS    = 8'd45;  // '-'
    localparam logic [7:0] CH_STAR     = 8'd42;  // '*'
    localparam logic [7:0] CH_SLASH    = 8'd47;  // '/'
    localparam logic [7:0] CH_LPAREN   = 8'd40;  // '('
    localparam logic [7:0] CH_RPAREN   = 8'd41;  // ')'

    // Exactly one field is set for any input byte.
    typedef struct packed {
        logic digit;
        logic op;
        logic lparen;
        logic rparen;
        logic other;
    } char_class_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational classifier: maps one ASCII byte to a one-hot character class.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  ch_i,
    output char_class_t class_o
);

    // Classify the byte; anything not explicitly recognised falls into 'other'.
    always_comb begin
        class_o = '0;
        if (ch_i >= CH_DIGIT_LO && ch_i <= CH_DIGIT_HI) begin
            class_o.digit = 1'b1;
        end else if (ch_i == CH_PLUS || ch_i == CH_MINUS ||
                     ch_i == CH_STAR || ch_i == CH_SLASH) begin
            class_o.op = 1'b1;
        end else if (ch_i == CH_LPAREN) begin
            class_o.lparen = 1'b1;
        end else if (ch_i == CH_RPAREN) begin
            class_o.rparen = 1'b1;
        end else begin
            class_o.other = 1'b1;
        end
    end

endmodule

// File: rtl/expr_checker.sv
// Streaming arithmetic-expression checker. One ASCII character is consumed
// per clock edge with in_valid high. out says the prefix seen so far is a
// complete balanced expression; err is sticky until clr. state_dbg_o exposes
// the FSM state for observation only.
//
// Handshake: there is no backpressure. A character is consumed on every
// posedge where in_valid=1 and clr=0; all outputs are registered decodes and
// reflect that character from the following cycle onwards.
module expr_checker
    import expr_pkg::*;
#(
    parameter int MAX_DEPTH   = 7,
    parameter int MULTI_DIGIT = 1,
    parameter int CNT_W       = 8,
    localparam int DW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             out,
    output logic             err,
    output logic [DW-1:0]    depth,
    output logic [CNT_W-1:0] terms,
    output logic [1:0]       state_dbg_o
);

    localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);

    state_e           state_q, state_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [CNT_W-1:0] terms_q, terms_d;
    char_class_t      cls;

    expr_char_class u_class (
        .ch_i    (in),
        .class_o (cls)
    );

    // State, depth and term-count registers; clr wins over any character.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EXPECT;
            depth_q <= '0;
            terms_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            terms_q <= terms_d;
        end
    end

    // Next-state logic; counters only move on a legal transition so they
    // freeze at their erroring-cycle values once ERR is entered.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        terms_d = terms_q;
        if (in_valid) begin
            case (state_q)
                EXPECT: begin
                    if (cls.digit) begin
                        state_d = DONE;
                        if (terms_q != '1) terms_d = terms_q + CNT_W'(1);
                    end else if (cls.lparen) begin
                        if (depth_q == DEPTH_MAX) state_d = ERR;
                        else                      depth_d = depth_q + DW'(1);
                    end else begin
                        state_d = ERR;
                    end
                end
                DONE: begin
                    if (cls.digit) begin
                        // Further digits extend the same operand, if allowed.
                        if (MULTI_DIGIT == 0) state_d = ERR;
                    end else if (cls.op) begin
                        state_d = EXPECT;
                    end else if (cls.rparen) begin
                        if (depth_q == '0) state_d = ERR;
                        else               depth_d = depth_q - DW'(1);
                    end else begin
                        state_d = ERR;
                    end
                end
                default: state_d = ERR;
            endcase
        end
    end

    // Registered-state output decode.
    always_comb begin
        out         = (state_q == DONE) && (depth_q == '0);
        err         = (state_q == ERR);
        depth       = depth_q;
        terms       = terms_q;
        state_dbg_o = state_q;
    end

endmodule

// File: tb/tb_expr_checker.sv
// Directed bench for expr_checker. Two instances: u0 with default parameters,
// u1 with MAX_DEPTH=2, MULTI_DIGIT=0, CNT_W=2 (depth limit, single digits and
// term saturation). Drivers push the hand-computed post-edge outputs into a
// per-instance queue; a monitor pops and compares after each consuming edge.
module tb_expr_checker;

    logic       clk;
    logic       clr0, clr1;
    logic [7:0] in0, in1;
    logic       v0, v1;

    logic       out0, err0;
    logic [2:0] depth0;
    logic [7:0] terms0;
    logic [1:0] st0;

    logic       out1, err1;
    logic [1:0] depth1;
    logic [1:0] terms1;
    logic [1:0] st1;

    logic [17:0] exp_q0[$];
    logic [17:0] exp_q1[$];
    logic        chk0, chk1;
    int          n_cmp, n_bad;
    int          step0, step1;

    expr_checker #(.MAX_DEPTH(7), .MULTI_DIGIT(1), .CNT_W(8)) u0 (
        .clk(clk), .clr(clr0), .in(in0), .in_valid(v0),
        .out(out0), .err(err0), .depth(depth0), .terms(terms0),
        .state_dbg_o(st0)
    );

    expr_checker #(.MAX_DEPTH(2), .MULTI_DIGIT(0), .CNT_W(2)) u1 (
        .clk(clk), .clr(clr1), .in(in1), .in_valid(v1),
        .out(out1), .err(err1), .depth(depth1), .terms(terms1),
        .state_dbg_o(st1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] e(input bit o, input bit er, input int dp, input int tm);
        logic [7:0] d8;
        logic [7:0] t8;
        d8 = dp[7:0];
        t8 = tm[7:0];
        return {o, er, d8, t8};
    endfunction

    // Driver: present one character for one edge, queueing the expected result.
    task automatic send(input int d, input logic [7:0] c, input logic [17:0] x);
        if (d == 0) begin
            in0 = c; v0 = 1'b1; exp_q0.push_back(x);
        end else begin
            in1 = c; v1 = 1'b1; exp_q1.push_back(x);
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    // Driver: pulse clr for one edge, optionally with a character alongside.
    task automatic clear(input int d, input bit with_char, input logic [7:0] c);
        if (d == 0) begin
            clr0 = 1'b1; v0 = with_char; in0 = c; exp_q0.push_back(e(0, 0, 0, 0));
        end else begin
            clr1 = 1'b1; v1 = with_char; in1 = c; exp_q1.push_back(e(0, 0, 0, 0));
        end
        @(posedge clk); #1;
        clr0 = 1'b0; clr1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Remember which edges consumed something (character or clr).
    always @(posedge clk) begin
        chk0 <= v0 | clr0;
        chk1 <= v1 | clr1;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [17:0] act;
        logic [17:0] x;
        if (chk0) begin
            act = {out0, err0, 8'(depth0), 8'(terms0)};
            n_cmp++;
            step0++;
            if (exp_q0.size() == 0) begin
                n_bad++;
                $display("FAIL u0 step %0d: output with empty expected queue", step0);
            end else begin
                x = exp_q0.pop_front();
                if (act !== x) begin
                    n_bad++;
                    $display("FAIL u0 step %0d: got out=%0b err=%0b depth=%0d terms=%0d, want out=%0b err=%0b depth=%0d terms=%0d",
                             step0, act[17], act[16], act[15:8], act[7:0], x[17], x[16], x[15:8], x[7:0]);
                end
            end
        end
        if (chk1) begin
            act = {out1, err1, 8'(depth1), 8'(terms1)};
            n_cmp++;
            step1++;
            if (exp_q1.size() == 0) begin
                n_bad++;
                $display("FAIL u1 step %0d: output with empty expected queue", step1);
            end else begin
                x = exp_q1.pop_front();
                if (act !== x) begin
                    n_bad++;
                    $display("FAIL u1 step %0d: got out=%0b err=%0b depth=%0d terms=%0d, want out=%0b err=%0b depth=%0d terms=%0d",
                             step1, act[17], act[16], act[15:8], act[7:0], x[17], x[16], x[15:8], x[7:0]);
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; step0 = 0; step1 = 0;
        chk0 = 1'b0; chk1 = 1'b0;
        in0 = 8'd0; in1 = 8'd0; v0 = 1'b0; v1 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        #1;

        // Reset both instances together.
        clr0 = 1'b1; clr1 = 1'b1;
        exp_q0.push_back(e(0, 0, 0, 0));
        exp_q1.push_back(e(0, 0, 0, 0));
        @(posedge clk); #1;
        clr0 = 1'b0; clr1 = 1'b0;

        // "12+3" multi-digit
        send(0, "1", e(1, 0, 0, 1));
        send(0, "2", e(1, 0, 0, 1));
        send(0, "+", e(0, 0, 0, 1));
        send(0, "3", e(1, 0, 0, 2));

        // "(4*(5-6))"
        clear(0, 0, 8'd0);
        send(0, "(", e(0, 0, 1, 0));
        send(0, "4", e(0, 0, 1, 1));
        send(0, "*", e(0, 0, 1, 1));
        send(0, "(", e(0, 0, 2, 1));
        send(0, "5", e(0, 0, 2, 2));
        send(0, "-", e(0, 0, 2, 2));
        send(0, "6", e(0, 0, 2, 3));
        send(0, ")", e(0, 0, 1, 3));
        send(0, ")", e(1, 0, 0, 3));

        // "3)" then further input stays in error
        clear(0, 0, 8'd0);
        send(0, "3", e(1, 0, 0, 1));
        send(0, ")", e(0, 1, 0, 1));
        send(0, "5", e(0, 1, 0, 1));

        // "+5"
        clear(0, 0, 8'd0);
        send(0, "+", e(0, 1, 0, 0));
        send(0, "5", e(0, 1, 0, 0));

        // "5 "
        clear(0, 0, 8'd0);
        send(0, "5", e(1, 0, 0, 1));
        send(0, " ", e(0, 1, 0, 1));

        // NUL in EXPECT, then "4(" (lparen after an operand)
        clear(0, 0, 8'd0);
        send(0, 8'd0, e(0, 1, 0, 0));
        clear(0, 0, 8'd0);
        send(0, "4", e(1, 0, 0, 1));
        send(0, "(", e(0, 1, 0, 1));

        // "7*(" then clr together with '9', then '9'
        clear(0, 0, 8'd0);
        send(0, "7", e(1, 0, 0, 1));
        send(0, "*", e(0, 0, 0, 1));
        send(0, "(", e(0, 0, 1, 1));
        clear(0, 1, "9");
        send(0, "9", e(1, 0, 0, 1));

        // "1+2" with idle gaps
        clear(0, 0, 8'd0);
        send(0, "1", e(1, 0, 0, 1));
        idle(2);
        send(0, "+", e(0, 0, 0, 1));
        idle(3);
        send(0, "2", e(1, 0, 0, 2));

        // Eight '(' with MAX_DEPTH=7
        clear(0, 0, 8'd0);
        for (int i = 1; i <= 7; i++) send(0, "(", e(0, 0, i, 0));
        send(0, "(", e(0, 1, 7, 0));

        // u1: "12" single-digit, error sticks
        send(1, "1", e(1, 0, 0, 1));
        send(1, "2", e(0, 1, 0, 1));
        send(1, "+", e(0, 1, 0, 1));

        // u1: "(((" with MAX_DEPTH=2
        clear(1, 0, 8'd0);
        send(1, "(", e(0, 0, 1, 0));
        send(1, "(", e(0, 0, 2, 0));
        send(1, "(", e(0, 1, 2, 0));

        // u1: "1+1+1+1+1" saturates the 2-bit term counter at 3
        clear(1, 0, 8'd0);
        send(1, "1", e(1, 0, 0, 1));
        send(1, "+", e(0, 0, 0, 1));
        send(1, "1", e(1, 0, 0, 2));
        send(1, "+", e(0, 0, 0, 2));
        send(1, "1", e(1, 0, 0, 3));
        send(1, "+", e(0, 0, 0, 3));
        send(1, "1", e(1, 0, 0, 3));
        send(1, "+", e(0, 0, 0, 3));
        send(1, "1", e(1, 0, 0, 3));

        // Drain: every queued expectation must have been consumed.
        idle(3);
        n_cmp++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: leftover expected u0=%0d u1=%0d, want 0 and 0",
                     exp_q0.size(), exp_q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
